// File: rtl/imem_uart_loader.sv
// Instruction-RAM loader: parses a UART byte-stream frame (MAGIC, COUNT, payload, CSUM),
// writes little-endian words into the RAM and holds the core in reset until a good load.
module imem_uart_loader #(
  parameter int          ADDR_W    = 10,
  parameter int          MAX_WORDS = 1024,
  parameter logic [7:0]  MAGIC     = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  // state  | meaning
  // IDLE   | waiting for MAGIC after reset
  // CNT_LO | next byte is count[7:0]
  // CNT_HI | next byte is count[15:8]
  // DATA   | collecting payload bytes into words
  // CSUM   | next byte is the checksum
  // DONE   | image loaded, core released
  // ERR    | frame rejected, core held
  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CSUM, DONE, ERR} state_t;

  state_t      state, state_nx;
  logic [15:0] count;
  logic [15:0] widx;
  logic [1:0]  bidx;
  logic [23:0] word_lo;
  logic [7:0]  csum;
  logic [15:0] count_rx;
  logic        magic_hit;
  logic        last_word;

  assign count_rx  = {rx_data, count[7:0]};
  assign magic_hit = rx_valid && (rx_data == MAGIC);
  assign last_word = (widx == (count - 16'd1));

  always_comb begin
    state_nx = state;
    if (rx_valid) begin
      case (state)
        IDLE, DONE, ERR: if (rx_data == MAGIC) state_nx = CNT_LO;
        CNT_LO:          state_nx = CNT_HI;
        CNT_HI: begin
          if (count_rx == 16'd0)                 state_nx = CSUM;
          else if (count_rx > 16'(MAX_WORDS))    state_nx = ERR;
          else                                   state_nx = DATA;
        end
        DATA:            if (bidx == 2'd3 && last_word) state_nx = CSUM;
        CSUM:            state_nx = (rx_data == csum) ? DONE : ERR;
        default:         state_nx = IDLE;
      endcase
    end
  end

  // hold rises combinationally on the reloading MAGIC strobe so the core never runs mid-reload
  always_comb begin
    cpu_hold  = (state != DONE) || magic_hit;
    load_done = (state == DONE);
    load_err  = (state == ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      widx      <= '0;
      bidx      <= '0;
      word_lo   <= '0;
      csum      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state  <= state_nx;
      mem_we <= 1'b0;
      if (rx_valid) begin
        case (state)
          IDLE, DONE, ERR: begin
            if (rx_data == MAGIC) begin
              count <= '0;
              widx  <= '0;
              bidx  <= '0;
              csum  <= '0;
            end
          end
          CNT_LO: count[7:0]  <= rx_data;
          CNT_HI: count[15:8] <= rx_data;
          DATA: begin
            csum <= csum + rx_data;
            bidx <= bidx + 2'd1;
            case (bidx)
              2'd0: word_lo[7:0]   <= rx_data;
              2'd1: word_lo[15:8]  <= rx_data;
              2'd2: word_lo[23:16] <= rx_data;
              default: begin
                mem_we    <= 1'b1;
                mem_addr  <= widx[ADDR_W-1:0];
                mem_wdata <= {rx_data, word_lo};
                widx      <= widx + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: expected RAM writes go into a scoreboard queue that a
// negedge monitor drains; status outputs are compared after each frame.
module tb_imem_uart_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold, load_done, load_err;

  int checks = 0;
  int passed = 0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [31:0]       exp_data_q[$];
  logic              prev_we = 1'b0;

  imem_uart_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(1024), .MAGIC(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // write monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        checks++;
        if (prev_we)
          $display("FAIL we_pulse: mem_we high two cycles in a row at addr %0d", mem_addr);
        else if (exp_addr_q.size() == 0)
          $display("FAIL unexpected_write: addr %0d data %h, none expected", mem_addr, mem_wdata);
        else begin
          logic [ADDR_W-1:0] ea;
          logic [31:0]       ed;
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          if (mem_addr !== ea || mem_wdata !== ed)
            $display("FAIL write: got addr %0d data %h, expected addr %0d data %h",
                     mem_addr, mem_wdata, ea, ed);
          else passed++;
        end
      end
      prev_we = mem_we;
    end else prev_we = 1'b0;
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic expect_word(input int a, input logic [31:0] d);
    exp_addr_q.push_back(ADDR_W'(a));
    exp_data_q.push_back(d);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic chk_status(input string name, input logic hold, input logic done, input logic err);
    @(negedge clk);
    chk({name, ".cpu_hold"},  32'(cpu_hold),  32'(hold));
    chk({name, ".load_done"}, 32'(load_done), 32'(done));
    chk({name, ".load_err"},  32'(load_err),  32'(err));
  endtask

  task automatic drain(input string name);
    repeat (4) @(negedge clk);
    chk({name, ".pending_writes"}, 32'(exp_addr_q.size()), 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] sum;
    logic [31:0] w;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_status("reset", 1'b1, 1'b0, 1'b0);
    chk("reset.mem_we", 32'(mem_we), 32'd0);

    // junk in IDLE is ignored
    send(8'h00); send(8'hFF); send(8'h13);
    chk_status("idle_junk", 1'b1, 1'b0, 1'b0);
    chk("idle_junk.mem_addr", 32'(mem_addr), 32'd0);
    chk("idle_junk.mem_wdata", mem_wdata, 32'd0);

    // two-word frame; payload sums to 0xDB
    expect_word(0, 32'h00200293);
    expect_word(1, 32'h00100313);
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h93); send(8'h02); send(8'h20); send(8'h00);
    send(8'h13); send(8'h03); send(8'h10); send(8'h00);
    send(8'hDB);
    chk_status("good2", 1'b0, 1'b1, 1'b0);
    drain("good2");

    // same payload, wrong checksum: words still written, frame rejected
    expect_word(0, 32'h00200293);
    expect_word(1, 32'h00100313);
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h93); send(8'h02); send(8'h20); send(8'h00);
    send(8'h13); send(8'h03); send(8'h10); send(8'h00);
    send(8'hC8);
    chk_status("badsum", 1'b1, 1'b0, 1'b1);
    drain("badsum");

    // count 1025 rejected at CNT_HI
    send(8'hA5); send(8'h01); send(8'h04);
    chk_status("oversize", 1'b1, 1'b0, 1'b1);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    chk_status("empty", 1'b0, 1'b1, 1'b0);
    drain("oversize");

    // reload from DONE: hold must rise during the MAGIC strobe itself
    @(posedge clk); #1;
    rx_data = 8'hA5; rx_valid = 1'b1;
    @(negedge clk);
    chk("reload.hold_on_strobe", 32'(cpu_hold), 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    expect_word(0, 32'h00000073);
    send(8'h01); send(8'h00);
    send(8'h73); send(8'h00); send(8'h00); send(8'h00);
    send(8'h73);
    chk_status("reload", 1'b0, 1'b1, 1'b0);
    drain("reload");

    // abort mid-frame with reset, then load a fresh frame
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h93); send(8'h02);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_status("midreset", 1'b1, 1'b0, 1'b0);
    chk("midreset.mem_we", 32'(mem_we), 32'd0);
    rst_n = 1'b1;
    expect_word(0, 32'h44332211);
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'hAA);
    chk_status("after_reset", 1'b0, 1'b1, 1'b0);
    drain("after_reset");

    // full-size frame: final address must be 1023 with no wrap
    sum = 8'h00;
    send(8'hA5); send(8'h00); send(8'h04);
    for (int i = 0; i < 1024; i++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++) begin
        b = 8'((i * 7 + j * 13 + 5) & 8'hFF);
        w[8*j +: 8] = b;
        sum = sum + b;
      end
      expect_word(i, w);
      for (int j = 0; j < 4; j++) send(w[8*j +: 8]);
    end
    send(sum);
    chk_status("maxframe", 1'b0, 1'b1, 1'b0);
    drain("maxframe");
    chk("maxframe.last_addr", 32'(mem_addr), 32'd1023);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
